// File: rtl/mips_int_ctrl_if.sv
// Bundle of interrupt pins, mask programming and the pipeline handshake
// between mips_int_ctrl and the exception logic.
interface mips_int_ctrl_if #(
    parameter int N_SRC = 4
);
    logic [N_SRC-1:0] irq_in;
    logic             mask_we;
    logic [N_SRC-1:0] mask_wdata;
    logic             int_ack;
    logic             eret;
    logic             int_req;
    logic [2:0]       int_id;
    logic             in_service;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] mask;

    // Pipeline / environment side: drives pins, mask writes and handshake.
    modport master (
        output irq_in, mask_we, mask_wdata, int_ack, eret,
        input  int_req, int_id, in_service, pending, mask
    );

    // Controller side.
    modport slave (
        input  irq_in, mask_we, mask_wdata, int_ack, eret,
        output int_req, int_id, in_service, pending, mask
    );
endinterface

// File: rtl/mips_int_ctrl.sv
// Interrupt controller: synchronises and edge-detects the request pins,
// keeps them pending, applies the software mask and hands the highest
// priority enabled source to the pipeline with a req/ack/eret handshake.
module mips_int_ctrl #(
    parameter int               N_SRC    = 4,
    parameter logic [N_SRC-1:0] MASK_RST = {N_SRC{1'b1}}
) (
    input logic          clk,
    input logic          rst,
    mips_int_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    logic [N_SRC-1:0] s1_q, s1_d;
    logic [N_SRC-1:0] s2_q, s2_d;
    logic [N_SRC-1:0] s3_q, s3_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] mask_q, mask_d;

    state_t           state_q, state_d;
    logic             int_req_q, int_req_d;
    logic [2:0]       int_id_q, int_id_d;
    logic             in_service_q, in_service_d;

    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] cand;
    logic [N_SRC-1:0] id_hot;
    logic [2:0]       winner_id;
    logic             winner_vld;
    logic             cur_active;
    logic             ack_fire;

    // Fixed-priority pick of the lowest enabled pending index, plus a
    // one-hot decode of the frozen int_id for per-source clear/withdraw.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        winner_id  = 3'd0;
        id_hot     = '0;
        cand       = pending_q & mask_q;
        winner_vld = |cand;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (cand[i]) winner_id = 3'(i);
            id_hot[i] = (int_id_q == 3'(i));
        end
        cur_active = |(id_hot & pending_q & mask_q);
        ack_fire   = (state_q == REQ) && bus.int_ack;
    end

    // Datapath next values: synchroniser chain, pending (set beats clear), mask.
    always_comb begin
        s1_d      = bus.irq_in;
        s2_d      = s1_q;
        s3_d      = s2_q;
        rise      = s2_q & ~s3_q;
        pending_d = (pending_q & ~(ack_fire ? id_hot : '0)) | rise;
        mask_d    = bus.mask_we ? bus.mask_wdata : mask_q;
    end

    // Datapath registers; s3 resets low so a pin held high at release fires.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            s3_q      <= '0;
            pending_q <= '0;
            mask_q    <= MASK_RST;
        end else begin
            // NOTE: non-blocking assignments make all flops update together
            // from pre-edge values, which is what the shift chain relies on.
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            s3_q      <= s3_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            int_req_q    <= 1'b0;
            int_id_q     <= 3'd0;
            in_service_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            int_req_q    <= int_req_d;
            int_id_q     <= int_id_d;
            in_service_q <= in_service_d;
        end
    end

    // FSM next state: ack wins over withdraw; stray ack/eret are ignored.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (winner_vld) state_d = REQ;
            REQ: begin
                if (bus.int_ack)      state_d = SERVICE;
                else if (!cur_active) state_d = IDLE;
            end
            SERVICE: if (bus.eret)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs for the next cycle; int_id is latched only on IDLE->REQ.
    always_comb begin
        int_req_d    = (state_d == REQ);
        in_service_d = (state_d == SERVICE);
        int_id_d     = int_id_q;
        if (state_q == IDLE && state_d == REQ) int_id_d = winner_id;
    end

    assign bus.int_req    = int_req_q;
    assign bus.int_id     = int_id_q;
    assign bus.in_service = in_service_q;
    assign bus.pending    = pending_q;
    assign bus.mask       = mask_q;

endmodule
